// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 memory-port arbiter.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BURST = 2'd1,
        D_BURST = 2'd2,
        D_WRITE = 2'd3
    } arb_state_t;

    localparam int LINE_OFFSET = 4;
    localparam int WORD_OFFSET = 2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; only the last-grant flag is stored.
module rr_arb2
    import cache_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_take,
    output logic o_gnt_vld,
    output logic o_gnt
);

    logic r_last_grant;

    always_comb begin
        o_gnt_vld = i_req_i | i_req_d;
        o_gnt     = GNT_I;
        if (i_req_i && i_req_d) begin
            o_gnt = (r_last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (i_req_d) begin
            o_gnt = GNT_D;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= GNT_I;
        end else if (i_take && o_gnt_vld) begin
            r_last_grant <= o_gnt;
        end
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one memory port between Icache line refills and Dcache refills /
// write-throughs, with a registered return path carrying per-beat word indices.
module l1_mem_arbiter
    import cache_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          I_req,
    input  logic [AW-1:0] I_addr,
    output logic          I_valid,
    output logic [1:0]    I_word,
    output logic          I_done,
    input  logic          D_req,
    input  logic          D_we,
    input  logic [AW-1:0] D_addr,
    input  logic [31:0]   D_wdata,
    output logic          D_valid,
    output logic [1:0]    D_word,
    output logic          D_done,
    output logic [31:0]   rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    arb_state_t             r_state;
    arb_state_t             w_next;
    logic [AW-1:WORD_OFFSET] r_addr;
    logic [31:0]            r_wdata;
    logic [1:0]             r_beat;
    logic                   r_I_valid, r_I_done, r_D_valid, r_D_done;
    logic [1:0]             r_I_word, r_D_word;
    logic [31:0]            r_rdata;
    logic                   w_req_i, w_req_d, w_gnt_vld, w_gnt, w_take;
    logic                   w_last, w_rd_burst;
    logic                   w_unused_bits;

    // A requester still holds its request during its own done cycle, so that
    // cycle must not count as a fresh request from the same side.
    assign w_req_i    = I_req & ~r_I_done;
    assign w_req_d    = D_req & ~r_D_done;
    assign w_take     = (r_state == IDLE);
    assign w_last     = (r_beat == LAST_BEAT);
    assign w_rd_burst = (r_state == I_BURST) || (r_state == D_BURST);
    assign w_unused_bits = ^{I_addr[WORD_OFFSET-1:0], D_addr[WORD_OFFSET-1:0]};

    rr_arb2 u_rr_arb2 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req_i   (w_req_i),
        .i_req_d   (w_req_d),
        .i_take    (w_take),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt     (w_gnt)
    );

    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    if (w_gnt == GNT_I) w_next = I_BURST;
                    else                w_next = D_we ? D_WRITE : D_BURST;
                end
            end
            I_BURST, D_BURST: begin
                mem_en   = 1'b1;
                mem_addr = {r_addr[AW-1:LINE_OFFSET], r_beat, {WORD_OFFSET{1'b0}}};
                if (mem_ready && w_last) w_next = IDLE;
            end
            D_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_addr, {WORD_OFFSET{1'b0}}};
                mem_wdata = r_wdata;
                if (mem_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_beat <= 2'd0;
            end else if (w_rd_burst && mem_ready && !w_last) begin
                r_beat <= r_beat + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_gnt_vld) begin
            r_addr  <= (w_gnt == GNT_I) ? I_addr[AW-1:WORD_OFFSET] : D_addr[AW-1:WORD_OFFSET];
            r_wdata <= D_wdata;
        end
    end

    // Return path: everything the caches see is one cycle behind mem_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_I_valid <= 1'b0;
            r_I_word  <= 2'd0;
            r_I_done  <= 1'b0;
            r_D_valid <= 1'b0;
            r_D_word  <= 2'd0;
            r_D_done  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_I_valid <= (r_state == I_BURST) && mem_ready;
            r_I_done  <= (r_state == I_BURST) && mem_ready && w_last;
            r_D_valid <= (r_state == D_BURST) && mem_ready;
            r_D_done  <= mem_ready && (((r_state == D_BURST) && w_last) || (r_state == D_WRITE));
            r_I_word  <= r_beat;
            r_D_word  <= r_beat;
            if (w_rd_burst && mem_ready) r_rdata <= mem_rdata;
        end
    end

    assign I_valid = r_I_valid;
    assign I_word  = r_I_word;
    assign I_done  = r_I_done;
    assign D_valid = r_D_valid;
    assign D_word  = r_D_word;
    assign D_done  = r_D_done;
    assign rdata   = r_rdata;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: transaction-level model, random memory stalls.
module tb_l1_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          I_req, D_req, D_we;
    logic [AW-1:0] I_addr, D_addr;
    logic [31:0]   D_wdata;
    logic          I_valid, I_done, D_valid, D_done;
    logic [1:0]    I_word, D_word;
    logic [31:0]   rdata;
    logic          mem_en, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    l1_mem_arbiter #(.BEATS(4), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .I_req(I_req), .I_addr(I_addr), .I_valid(I_valid), .I_word(I_word), .I_done(I_done),
        .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_valid(D_valid), .D_word(D_word), .D_done(D_done),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mem_exp_t;
    typedef struct { logic [1:0] word; logic [31:0] data; logic done; logic wr; } ret_exp_t;

    mem_exp_t mem_q[$];
    ret_exp_t ri_q[$];
    ret_exp_t rd_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit model_last;      // 0 = I granted last, 1 = D granted last
    bit rand_stall = 0;
    int stall_seq  = 0;

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    task automatic check(input string name, input bit ok, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected memory beats and return beats for one transaction of one side.
    task automatic enq(input bit side_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] a;
        ret_exp_t r;
        if (side_d && we) begin
            mem_q.push_back('{{addr[31:2], 2'b00}, 1'b1, wdata});
            r = '{2'd0, 32'd0, 1'b1, 1'b1};
            rd_q.push_back(r);
        end else begin
            for (int k = 0; k < 4; k++) begin
                a = {addr[31:4], 2'(k), 2'b00};
                mem_q.push_back('{a, 1'b0, 32'd0});
                r = '{2'(k), data_fn(a), (k == 3), 1'b0};
                if (side_d) rd_q.push_back(r);
                else        ri_q.push_back(r);
            end
        end
    endtask

    task automatic cycles_until(input int sel, output int n);
        bit hit;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = mem_en;
                1:       hit = I_done;
                default: hit = D_done;
            endcase
        end while (!hit && n < 400);
        if (!hit) check("wait_timeout", 1'b0, 96'(sel), 96'(n));
    endtask

    task automatic drive_one(input bit side_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        enq(side_d, we, addr, wdata);
        if (side_d) begin
            D_we = we; D_addr = addr; D_wdata = wdata; D_req = 1'b1;
            cycles_until(2, n);
            D_req = 1'b0;
        end else begin
            I_addr = addr; I_req = 1'b1;
            cycles_until(1, n);
            I_req = 1'b0;
        end
        model_last = side_d;
    endtask

    task automatic run_pair(input logic [31:0] ia, input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
        bit d_first;
        d_first = (model_last == 1'b0);
        if (d_first) begin enq(1'b1, dwe, da, dwd); enq(1'b0, 1'b0, ia, 32'd0); end
        else         begin enq(1'b0, 1'b0, ia, 32'd0); enq(1'b1, dwe, da, dwd); end
        I_addr = ia; D_we = dwe; D_addr = da; D_wdata = dwd;
        I_req = 1'b1; D_req = 1'b1;
        fork
            begin int ni; cycles_until(1, ni); I_req = 1'b0; end
            begin int nd; cycles_until(2, nd); D_req = 1'b0; end
        join
        model_last = d_first ? 1'b0 : 1'b1;
    endtask

    task automatic mem_proc();
        int seen = 0;
        int stall_cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_seq != seen) begin seen = stall_seq; stall_cnt = 3; end
            if (!mem_en) mem_ready = 1'b0;
            else if (stall_cnt > 0 && mem_addr[3:2] == 2'd2) begin mem_ready = 1'b0; stall_cnt--; end
            else if (rand_stall) mem_ready = ($urandom_range(0, 2) != 0);
            else mem_ready = 1'b1;
            mem_rdata = mem_ready ? data_fn(mem_addr) : $urandom;
        end
    endtask

    task automatic mon_proc();
        mem_exp_t    me;
        ret_exp_t    re;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_addr = '0;
        logic        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall)
                check("mem_hold", mem_en && mem_addr == prev_addr && mem_we == prev_we,
                      {mem_en, mem_we, mem_addr}, {1'b1, prev_we, prev_addr});
            prev_stall = mem_en && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            if (mem_en) check("busy_during_access", busy, 96'(busy), 96'(1));
            if (mem_en && mem_ready) begin
                if (mem_q.size() == 0) check("mem_unexpected", 1'b0, {mem_we, mem_addr}, 96'(0));
                else begin
                    me = mem_q.pop_front();
                    check("mem_beat", mem_addr == me.addr && mem_we == me.we && (!me.we || mem_wdata == me.wdata),
                          {mem_we, mem_addr, mem_wdata}, {me.we, me.addr, me.wdata});
                end
            end
            if (I_valid) begin
                if (ri_q.size() == 0) check("I_unexpected", 1'b0, {I_word, rdata}, 96'(0));
                else begin
                    re = ri_q.pop_front();
                    check("I_beat", I_word == re.word && rdata == re.data && I_done == re.done,
                          {I_done, I_word, rdata}, {re.done, re.word, re.data});
                end
            end else if (I_done) check("I_done_no_valid", 1'b0, 96'(1), 96'(0));
            if (D_valid || D_done) begin
                if (rd_q.size() == 0) check("D_unexpected", 1'b0, {D_valid, D_done, D_word, rdata}, 96'(0));
                else begin
                    re = rd_q.pop_front();
                    if (re.wr)
                        check("D_write_done", !D_valid && D_done, {D_valid, D_done}, {1'b0, 1'b1});
                    else
                        check("D_beat", D_valid && D_word == re.word && rdata == re.data && D_done == re.done,
                              {D_valid, D_done, D_word, rdata}, {1'b1, re.done, re.word, re.data});
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; I_req = 1'b0; I_addr = '0; D_req = 1'b0; D_we = 1'b0; D_addr = '0; D_wdata = '0;
        model_last = 1'b0;
        fork
            mem_proc();
            mon_proc();
        join_none
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {I_valid, I_done, I_word, D_valid, D_done, D_word, mem_en, mem_we, busy} == '0,
              {I_valid, I_done, I_word, D_valid, D_done, D_word, mem_en, mem_we, busy}, 96'(0));
        check("reset_data", rdata == 0 && mem_addr == 0 && mem_wdata == 0, {rdata, mem_addr, mem_wdata}, 96'(0));

        // Ties: D first after reset, then I wins once D was granted last.
        run_pair(32'h0000_4450, 1'b0, 32'h8000_7700, 32'd0);
        drive_one(1'b1, 1'b1, 32'h8000_1008, 32'h1234_5678);
        run_pair(32'h0000_5560, 1'b0, 32'h8000_6610, 32'd0);

        // Lone I refill with zero-wait memory and latency checks.
        enq(1'b0, 1'b0, 32'h0000_1234, 32'd0);
        I_addr = 32'h0000_1234; I_req = 1'b1;
        cycles_until(0, n); check("I_en_latency", n == 1, 96'(n), 96'(1));
        cycles_until(1, n); check("I_done_latency", n == 4, 96'(n), 96'(4));
        I_req = 1'b0; model_last = 1'b0;

        // Write-through timing.
        enq(1'b1, 1'b1, 32'h0000_2007, 32'hDEAD_BEEF);
        D_we = 1'b1; D_addr = 32'h0000_2007; D_wdata = 32'hDEAD_BEEF; D_req = 1'b1;
        cycles_until(0, n); check("D_wr_en_latency", n == 1, 96'(n), 96'(1));
        check("D_wr_strobe", mem_we && mem_addr == 32'h2004 && mem_wdata == 32'hDEAD_BEEF,
              {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h2004, 32'hDEAD_BEEF});
        cycles_until(2, n); check("D_wr_done_latency", n == 1, 96'(n), 96'(1));
        D_req = 1'b0; model_last = 1'b1;

        // Three wait states on beat 2 stretch the burst to 7 cycles.
        enq(1'b0, 1'b0, 32'h0000_3A0C, 32'd0);
        stall_seq++;
        I_addr = 32'h0000_3A0C; I_req = 1'b1;
        cycles_until(0, n);
        cycles_until(1, n); check("stall_burst_len", n == 7, 96'(n), 96'(7));
        I_req = 1'b0; model_last = 1'b0;

        // Back-to-back I: next request presented during the done cycle.
        enq(1'b0, 1'b0, 32'h0000_0100, 32'd0);
        I_addr = 32'h0000_0100; I_req = 1'b1;
        cycles_until(1, n);
        enq(1'b0, 1'b0, 32'h0000_0200, 32'd0);
        I_addr = 32'h0000_0200;
        cycles_until(0, n); check("b2b_gap", n == 2, 96'(n), 96'(2));
        cycles_until(1, n);
        I_req = 1'b0; model_last = 1'b0;

        // Reset after beat 1 has returned; beat 2 is accepted in that same cycle.
        for (int k = 0; k < 3; k++) mem_q.push_back('{{28'h0000_9AB, 2'(k), 2'b00}, 1'b0, 32'd0});
        for (int k = 0; k < 2; k++) ri_q.push_back('{2'(k), data_fn({28'h0000_9AB, 2'(k), 2'b00}), 1'b0, 1'b0});
        I_addr = 32'h0000_9AB0; I_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(I_valid && I_word == 2'd1) && n < 400);
        check("reset_test_reach_beat1", n < 400, 96'(n), 96'(3));
        rst = 1'b1; I_req = 1'b0;
        @(negedge clk);
        check("midburst_reset", {mem_en, busy, I_done, I_valid} == 4'b0 && rdata == 0,
              {mem_en, busy, I_done, I_valid, rdata}, 96'(0));
        rst = 1'b0; model_last = 1'b0;
        @(negedge clk);
        drive_one(1'b0, 1'b0, 32'h0000_9AB0, 32'd0);

        // Randomised mix with random memory stalls.
        rand_stall = 1'b1;
        for (int t = 0; t < 30; t++) begin
            logic [31:0] ia, da, dw;
            int kind;
            ia = {1'b0, 31'($urandom)};
            da = {1'b1, 31'($urandom)};
            dw = $urandom;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       drive_one(1'b0, 1'b0, ia, 32'd0);
                1:       drive_one(1'b1, 1'b0, da, 32'd0);
                2:       drive_one(1'b1, 1'b1, da, dw);
                default: run_pair(ia, 1'($urandom_range(0, 1)), da, dw);
            endcase
        end
        repeat (4) @(negedge clk);
        check("queues_drained", mem_q.size() + ri_q.size() + rd_q.size() == 0,
              96'(mem_q.size() + ri_q.size() + rd_q.size()), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
